// File: rtl/mips_hilo_pkg.sv
// rtl/mips_hilo_pkg.sv - shared types and constants for the HI/LO and divider unit
package mips_hilo_pkg;

  localparam int DIV_ITERS  = 32;
  localparam int ITER_CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIXUP,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_seq.sv
// rtl/div_seq.sv - sequential restoring divider for DIV/DIVU with sign fixup
module div_seq
  import mips_hilo_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             wr_en,
  output logic             div_busy,
  output logic             div_done,
  output logic             div_zero
);

  localparam logic [ITER_CNT_W-1:0] LAST_STEP = ITER_CNT_W'(WIDTH - 1);

  div_state_t              state_q, state_d;
  logic [WIDTH-1:0]        dvd_q, dvd_d;
  logic [WIDTH-1:0]        dvs_q, dvs_d;
  logic                    sgn_q, sgn_d;
  logic [WIDTH-1:0]        mag_q, mag_d;
  logic [WIDTH-1:0]        rem_q, rem_d;
  logic [WIDTH-1:0]        quo_q, quo_d;
  logic [ITER_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    neg_quo_q, neg_quo_d;
  logic                    neg_rem_q, neg_rem_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    zero_q, zero_d;
  logic                    wr_en_q, wr_en_d;
  logic [WIDTH:0]          trial;

  // Trial remainder is one bit wider so a borrow shows up in the MSB.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, mag_q};

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    sgn_d     = sgn_q;
    mag_d     = mag_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    done_d    = 1'b0;
    zero_d    = 1'b0;
    wr_en_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (div_start) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          sgn_d   = div_signed;
          state_d = PREP;
        end
      end
      PREP: begin
        if (dvs_q == '0) begin
          zero_d  = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          quo_d     = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
          mag_d     = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          neg_rem_d = sgn_q & dvd_q[WIDTH-1];
          state_d   = ITER;
        end
      end
      ITER: begin
        rem_d = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + ITER_CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          wr_en_d = 1'b1;
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      sgn_q     <= 1'b0;
      mag_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      zero_q    <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      sgn_q     <= sgn_d;
      mag_q     <= mag_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      zero_q    <= zero_d;
      wr_en_q   <= wr_en_d;
    end
  end

  // wr_en is high for the FIXUP cycle, when the magnitudes are final.
  assign quotient  = neg_quo_q ? -quo_q : quo_q;
  assign remainder = neg_rem_q ? -rem_q : rem_q;
  assign wr_en     = wr_en_q;
  assign div_busy  = busy_q;
  assign div_done  = done_q;
  assign div_zero  = zero_q;

endmodule

// File: rtl/hilo_div_unit.sv
// rtl/hilo_div_unit.sv - architectural HI/LO registers fed by multiplier, divider and MTHI/MTLO
module hilo_div_unit
  import mips_hilo_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic [2*WIDTH-1:0] mul_result,
  input  logic               mult_done,
  input  logic               div_start,
  input  logic               div_signed,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic               mthi_en,
  input  logic               mtlo_en,
  input  logic [WIDTH-1:0]   move_data,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output logic               div_busy,
  output logic               div_done,
  output logic               div_zero
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             div_wr;

  div_seq #(
    .WIDTH(WIDTH)
  ) u_div_seq (
    .clk       (Clk),
    .rst_n     (reset),
    .div_start (div_start),
    .div_signed(div_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (div_quo),
    .remainder (div_rem),
    .wr_en     (div_wr),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_zero  (div_zero)
  );

  // Divider result beats a same-edge multiply, which beats MTHI/MTLO.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_wr) begin
      hi_d = div_rem;
      lo_d = div_quo;
    end else if (mult_done) begin
      hi_d = mul_result[2*WIDTH-1:WIDTH];
      lo_d = mul_result[WIDTH-1:0];
    end else begin
      if (mthi_en) hi_d = move_data;
      if (mtlo_en) lo_d = move_data;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// tb/tb_hilo_div_unit.sv - self-checking bench for hilo_div_unit
module tb_hilo_div_unit;

  logic        clk;
  logic        rst_n;
  logic [63:0] mul_result;
  logic        mult_done;
  logic        div_start;
  logic        div_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        mthi_en;
  logic        mtlo_en;
  logic [31:0] move_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        div_busy;
  logic        div_done;
  logic        div_zero;

  int          n_vec;
  int          n_mis;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  hilo_div_unit dut (
    .Clk       (clk),
    .reset     (rst_n),
    .mul_result(mul_result),
    .mult_done (mult_done),
    .div_start (div_start),
    .div_signed(div_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .mthi_en   (mthi_en),
    .mtlo_en   (mtlo_en),
    .move_data (move_data),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of DIV/DIVU: truncating division, remainder takes dividend sign.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    if (b == 32'd0) begin
      q = '0;
      r = '0;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else begin
      sa = $signed(a);
      sb = $signed(b);
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end
  endfunction

  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input int mul_at, input string tag);
    logic [31:0] eq;
    logic [31:0] er;
    logic [63:0] prod;
    int          exp_k;
    int          k;
    logic        busy_ok;
    ref_div(sgn, a, b, eq, er);
    exp_k      = (b == 32'd0) ? 1 : 34;
    prod       = '0;
    div_start  = 1'b1;
    div_signed = sgn;
    dividend   = a;
    divisor    = b;
    tick();
    div_start  = 1'b0;
    dividend   = $urandom;
    divisor    = $urandom;
    div_signed = 1'($urandom);
    chk({tag, "_busy_e0"}, {31'b0, div_busy}, 32'd1);
    busy_ok = 1'b1;
    k = 0;
    while (k < 40) begin
      div_start = (k == poke_at);
      if (k == poke_at) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
      mult_done = (k == mul_at);
      if (k == mul_at) begin
        prod       = {$urandom, $urandom};
        mul_result = prod;
      end
      tick();
      k++;
      if (k - 1 == mul_at) begin
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
      end
      if (div_done) break;
      if (!div_busy) busy_ok = 1'b0;
      if (k - 1 == mul_at) begin
        chk({tag, "_mul_hi"}, hi_out, exp_hi);
        chk({tag, "_mul_lo"}, lo_out, exp_lo);
      end
    end
    div_start = 1'b0;
    mult_done = 1'b0;
    if (b != 32'd0) begin
      exp_hi = er;
      exp_lo = eq;
    end
    chk({tag, "_done_edge"}, 32'(k), 32'(exp_k));
    chk({tag, "_busy_run"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_zero"}, {31'b0, div_zero}, {31'b0, b == 32'd0});
    chk({tag, "_hi"}, hi_out, exp_hi);
    chk({tag, "_lo"}, lo_out, exp_lo);
    tick();
    chk({tag, "_done_clr"}, {31'b0, div_done}, 32'd0);
    chk({tag, "_zero_clr"}, {31'b0, div_zero}, 32'd0);
    chk({tag, "_busy_clr"}, {31'b0, div_busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] md;
    logic [63:0] prod;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    n_vec      = 0;
    n_mis      = 0;
    exp_hi     = '0;
    exp_lo     = '0;
    rst_n      = 1'b0;
    mul_result = '0;
    mult_done  = 1'b0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    dividend   = '0;
    divisor    = '0;
    mthi_en    = 1'b0;
    mtlo_en    = 1'b0;
    move_data  = '0;

    tick();
    tick();
    chk("rst_hi", hi_out, 32'd0);
    chk("rst_lo", lo_out, 32'd0);
    chk("rst_busy", {31'b0, div_busy}, 32'd0);
    chk("rst_done", {31'b0, div_done}, 32'd0);
    chk("rst_zero", {31'b0, div_zero}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_div(1'b0, 32'd100, 32'd7, -1, -1, "divu_100_7");
    chk("divu_lo_const", lo_out, 32'd14);
    chk("divu_hi_const", hi_out, 32'd2);

    do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1, "div_m7_2");
    chk("div_m7_lo_const", lo_out, 32'hFFFF_FFFD);
    chk("div_m7_hi_const", hi_out, 32'hFFFF_FFFF);

    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, "div_ovf");
    chk("div_ovf_lo_const", lo_out, 32'h8000_0000);
    chk("div_ovf_hi_const", hi_out, 32'h0000_0000);

    mthi_en   = 1'b1;
    move_data = 32'hAAAA_AAAA;
    tick();
    mthi_en   = 1'b0;
    mtlo_en   = 1'b1;
    move_data = 32'h5555_5555;
    tick();
    mtlo_en   = 1'b0;
    exp_hi    = 32'hAAAA_AAAA;
    exp_lo    = 32'h5555_5555;
    chk("mthi_pre", hi_out, 32'hAAAA_AAAA);
    chk("mtlo_pre", lo_out, 32'h5555_5555);
    do_div(1'b1, 32'd5, 32'd0, -1, -1, "div_zero");
    chk("dz_hi_const", hi_out, 32'hAAAA_AAAA);
    chk("dz_lo_const", lo_out, 32'h5555_5555);

    mult_done  = 1'b1;
    mul_result = 64'h0000_0001_FFFF_FFFE;
    mthi_en    = 1'b1;
    move_data  = 32'h1234_5678;
    tick();
    mult_done  = 1'b0;
    mthi_en    = 1'b0;
    chk("mul_prio_hi", hi_out, 32'h0000_0001);
    chk("mul_prio_lo", lo_out, 32'hFFFF_FFFE);
    md        = $urandom;
    mtlo_en   = 1'b1;
    move_data = md;
    tick();
    mtlo_en   = 1'b0;
    chk("mtlo_only_lo", lo_out, md);
    chk("mtlo_only_hi", hi_out, 32'h0000_0001);
    exp_hi = 32'h0000_0001;
    exp_lo = md;

    do_div(1'b0, 32'd100, 32'd7, 9, -1, "busy_poke");
    chk("busy_poke_lo_const", lo_out, 32'd14);
    chk("busy_poke_hi_const", hi_out, 32'd2);

    do_div(1'b1, 32'd1234567, 32'hFFFF_FF00, -1, 33, "fixup_vs_mul");

    div_start  = 1'b1;
    div_signed = 1'b0;
    dividend   = 32'd1000;
    divisor    = 32'd3;
    tick();
    div_start  = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    chk("arst_busy", {31'b0, div_busy}, 32'd0);
    chk("arst_hi", hi_out, 32'd0);
    chk("arst_lo", lo_out, 32'd0);
    chk("arst_done", {31'b0, div_done}, 32'd0);
    tick();
    tick();
    chk("arst_hold_done", {31'b0, div_done}, 32'd0);
    chk("arst_hold_busy", {31'b0, div_busy}, 32'd0);
    rst_n = 1'b1;
    tick();
    do_div(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, -1, -1, "post_rst");
    chk("post_rst_lo_const", lo_out, 32'h0FFF_FFFF);
    chk("post_rst_hi_const", hi_out, 32'h0000_000F);

    for (int n = 0; n < 16; n++) begin
      mult_done  = 1'($urandom);
      mthi_en    = 1'($urandom);
      mtlo_en    = 1'($urandom);
      prod       = {$urandom, $urandom};
      md         = $urandom;
      mul_result = prod;
      move_data  = md;
      if (mult_done) begin
        exp_hi = prod[63:32];
        exp_lo = prod[31:0];
      end else begin
        if (mthi_en) exp_hi = md;
        if (mtlo_en) exp_lo = md;
      end
      tick();
      mult_done = 1'b0;
      mthi_en   = 1'b0;
      mtlo_en   = 1'b0;
      chk("rnd_move_hi", hi_out, exp_hi);
      chk("rnd_move_lo", lo_out, exp_lo);

      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: b = 32'h8000_0000;
        default: b = (n % 5 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      endcase
      do_div(sgn, a, b, (n % 3 == 0) ? int'($urandom_range(0, 30)) : -1,
             (b == 32'd0) ? -1 : int'($urandom_range(0, 33)), "rnd_div");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
